lab_design_serial_subtractor: RTL and testbench
===============================================

Name: lab_design_serial_subtractor

Overview:
Bit-serial subtractor that computes a - b - bin over WIDTH clock cycles. It uses a single full-subtractor cell plus a registered borrow, processing LSB first. This is the subtract-direction counterpart to the ripple full-adder datapath in the 4-bit ALU. It offers a start/busy/done handshake so the ALU/7-segment top level can launch an operation and latch the result.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result, held stable from done until the next accepted start
bout  output  1  final borrow (1 = unsigned a < b + bin)
ovf  output  1  two's-complement overflow of the subtraction

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, diff, bout, ovf, shift registers, borrow and counter all 0. Deasserting reset mid-operation does not resume; the aborted operation is lost.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 does the following:
  - capture a, b into shift registers;
  - borrow register := bin;
  - save a[WIDTH-1] and b[WIDTH-1] for the overflow check;
  - count := 0; go to SHIFT.
- SHIFT: busy=1. At each edge E1..EWIDTH, with x=a_sr[0], y=b_sr[0], r=borrow:
  - d = x^y^r;
  - borrow := (~x&y) | (~(x^y)&r);
  - d shifts into the result register from the MSB side (result := {d, result[WIDTH-1:1]});
  - a_sr and b_sr shift right by 1;
  - count increments.
- At EWIDTH (count reaches WIDTH-1 before the edge), go to DONE and update the outputs:
  - diff := final result register;
  - bout := final borrow;
  - ovf := (a_msb != b_msb) & (diff_msb != a_msb).
- DONE: done=1, busy=0 for exactly one cycle; unconditional return to IDLE at the next edge.
- Latency: start accepted at E0 -> done high during the cycle after EWIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while SHIFT or DONE: ignored; no effect on the captured operands or the in-flight result.
- a, b, bin may change freely after acceptance; only the values captured at E0 matter.
- diff, bout and ovf change only at the SHIFT->DONE edge and hold otherwise, including through IDLE.
- busy and done are registered outputs, never high simultaneously.
- Counter width is clog2(WIDTH)+1. No wrap-around is reachable, because the count leaves SHIFT at WIDTH-1.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, then release with start=0 -> busy=0, done=0, diff=0, bout=0, ovf=0 held indefinitely.
2. WIDTH=4, a=9, b=3, bin=0, start for 1 cycle -> busy high 4 cycles, then done pulse 1 cycle; diff=6, bout=0, ovf=1.
3. a=3, b=5, bin=0 -> diff=14 (4'b1110), bout=1, ovf=0. Next, a=5, b=5 -> diff=0, bout=0, ovf=0. Both the values and the held result must be checked after done.
4. a=0, b=0, bin=1 -> diff=15, bout=1, ovf=0. Then a=8, b=1, bin=0 -> diff=7, bout=0, ovf=1.
5. Start a=9, b=3; assert start with a=1, b=1 during SHIFT and during DONE -> both ignored; result diff=6; exactly one done pulse.
6. Start a=12, b=4; pull rst_n low after 2 SHIFT cycles for 1 cycle -> all outputs 0 immediately (asynchronous), no done pulse. A fresh start with a=12, b=4 -> diff=8, bout=0, ovf=0.

Source files
------------

// File: rtl/lab_design_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Ports: clk, rst_n; start/a/b/bin in; busy/done/diff/bout/ovf out.
module lab_design_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_brw;
  logic [WIDTH-1:0] w_res;
  logic             w_last;

  // single full-subtractor cell
  assign w_x    = r_a_sr[0];
  assign w_y    = r_b_sr[0];
  assign w_d    = w_x ^ w_y ^ r_brw;
  assign w_brw  = (~w_x & w_y) | (~(w_x ^ w_y) & r_brw);
  assign w_res  = {w_d, r_res[WIDTH-1:1]};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_res  <= w_res;
          r_brw  <= w_brw;
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            diff    <= w_res;
            bout    <= w_brw;
            // w_d is the result MSB on the final step
            ovf     <= (r_a_msb != r_b_msb) &
                       (w_d != r_a_msb);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab_design_serial_subtractor.sv
// Bench for lab_design_serial_subtractor.
// Directed plus random operations; done-driven scoreboard.
module tb_lab_design_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  logic [W-1:0] h_diff = '0;
  logic         h_bout = 1'b0;
  logic         h_ovf  = 1'b0;

  lab_design_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         ibin
  );
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, ia} - {1'b0, ib} - (W+1)'(ibin);
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (ia[W-1] != ib[W-1]) &&
             (e.diff[W-1] != ia[W-1]);
    return e;
  endfunction

  // monitor: pops on done, otherwise checks the held result
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      h_diff = '0;
      h_bout = 1'b0;
      h_ovf  = 1'b0;
    end else begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done busy=%0b done=%0b required not both",
                 busy, done);
      end
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done done=1 required no pending op");
        end else begin
          exp_t e;
          e = q.pop_front();
          h_diff = e.diff;
          h_bout = e.bout;
          h_ovf  = e.ovf;
        end
      end
      if (diff !== h_diff || bout !== h_bout || ovf !== h_ovf) begin
        errors++;
        $display("FAIL result diff=%0d bout=%0b ovf=%0b required %0d %0b %0b",
                 diff, bout, ovf, h_diff, h_bout, h_ovf);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endtask

  // called at posedge+1 with the DUT idle
  task automatic op(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         ibin,
    input bit           junk
  );
    int n;
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    @(posedge clk);
    q.push_back(model(ia, ib, ibin));
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    chk("busy_after_start", int'(busy), 1);
    if (junk) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
    end else begin
      n = 0;
    end
    while (!done && n < W + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, W);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    idle(8);
    chk("idle_busy", int'(busy), 0);

    op(4'd9, 4'd3, 1'b0, 1'b0);
    chk("t2_diff", int'(diff), 6);
    chk("t2_ovf", int'(ovf), 1);
    op(4'd3, 4'd5, 1'b0, 1'b0);
    idle(3);
    chk("t3_diff", int'(diff), 14);
    chk("t3_bout", int'(bout), 1);
    op(4'd5, 4'd5, 1'b0, 1'b0);
    idle(2);
    chk("t3b_diff", int'(diff), 0);
    op(4'd0, 4'd0, 1'b1, 1'b0);
    chk("t4_diff", int'(diff), 15);
    chk("t4_bout", int'(bout), 1);
    op(4'd8, 4'd1, 1'b0, 1'b0);
    chk("t4b_diff", int'(diff), 7);
    chk("t4b_ovf", int'(ovf), 1);

    // start asserted during SHIFT and during DONE
    dn    = n_done;
    a     = 4'd9;
    b     = 4'd3;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    q.push_back(model(4'd9, 4'd3, 1'b0));
    #1;
    a = 4'd1;
    b = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int n = 1;
      while (!done && n < W + 4) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("t5_latency", n, W);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle(2);
    chk("t5_busy", int'(busy), 0);
    chk("t5_diff", int'(diff), 6);
    chk("t5_ndone", n_done - dn, 1);

    // asynchronous reset in the middle of SHIFT
    a     = 4'd12;
    b     = 4'd4;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_diff", int'(diff), 0);
    chk("t6_bout_ovf", int'({bout, ovf}), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dn = n_done;
    idle(W + 3);
    chk("t6_no_done", n_done - dn, 0);
    op(4'd12, 4'd4, 1'b0, 1'b0);
    chk("t6b_diff", int'(diff), 8);

    for (int i = 0; i < 60; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom),
         1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
